hp_ctrl: RTL
============

# hp_ctrl

Game-side owner of both players' hit points: accepts damage events from the projectile/collision logic and decrements per-player HP with saturation at zero. It also runs the round state machine (idle, play, drain, over). Its `hp_player1` and `hp_player2` outputs drive the HP-bar overlay stage of the VGA pipeline. Displayed HP drains toward the true HP by a fixed step once per video frame, so bars shrink visibly instead of jumping.

## Interface
Parameters:
- `HP_MAX`, default `7'd100`: full HP at round start. Must be ≤ 127.
- `DRAIN_STEP`, default `7'd1`: maximum displayed-HP decrement per frame tick. Must be ≥ 1.

Ports:
- `clk60MHz`  in  1  system/pixel clock; one clock only.
- `rst`  in  1  reset, asynchronous, active-high.
- `new_game`  in  1  single-cycle pulse; starts or restarts a round from any state.
- `vblnk`  in  1  vertical blank from the VGA timing chain; its rising edge is the frame tick.
- `hit1_valid`  in  1  single-cycle pulse; player 1 takes damage.
- `hit1_dmg`  in  7  damage for player 1; sampled only when `hit1_valid`=1.
- `hit2_valid`  in  1  single-cycle pulse; player 2 takes damage.
- `hit2_dmg`  in  7  damage for player 2; sampled only when `hit2_valid`=1.
- `hp_player1`  out  7  displayed HP, player 1 (registered).
- `hp_player2`  out  7  displayed HP, player 2 (registered).
- `game_over`  out  1  high in OVER state (registered).
- `winner`  out  2  result: 00 none, 01 player 1 wins, 10 player 2 wins, 11 draw (registered).

## Operation
- Internal registers per player:
  - `tgt_hpN`: true HP.
  - `hp_playerN`: displayed HP.
  - `vblnk_d`: previous `vblnk`.
- Frame tick: `tick = vblnk & ~vblnk_d`.
- States: IDLE, PLAY, DRAIN, OVER.
  - IDLE: hits ignored; targets and displayed values held at HP_MAX.
  - PLAY: a hit with `hitN_valid`=1 sets `tgt_hpN <= (hitN_dmg >= tgt_hpN) ? 0 : tgt_hpN - hitN_dmg`. Both players update independently in the same cycle. If either next target equals 0, go to DRAIN.
  - DRAIN: hits ignored; drain continues. Once both `hp_playerN == tgt_hpN`, go to OVER and latch `winner`:
    - only `tgt_hp1`=0 → 10
    - only `tgt_hp2`=0 → 01
    - both 0 → 11
  - OVER: `game_over`=1 and `winner` is held. Hits are ignored.
- `new_game` has priority over every other event in every state. On the next edge: targets = HP_MAX, displayed = HP_MAX, `winner`=00, `game_over`=0, state = PLAY.
- Drain, on each `tick` in PLAY or DRAIN, per player: if `hp_playerN > tgt_hpN`, then `hp_playerN <= hp_playerN - min(DRAIN_STEP, hp_playerN - tgt_hpN)`. The comparison uses the registered (pre-hit) target. No undershoot is allowed.
- All arithmetic is unsigned 7-bit. The compare-before-subtract rule guarantees no wrap-around.

## Timing
- Reset (async assert, released synchronously to `clk60MHz` by the reset tree):
  - state IDLE
  - `tgt_hpN` = HP_MAX, `hp_playerN` = HP_MAX
  - `vblnk_d`=0, `game_over`=0, `winner`=00
- Hit latency: a pulse sampled at edge N updates `tgt_hpN` at edge N. The displayed value moves at the first tick after that edge.
- Hit and tick in the same cycle: the drain step uses the old target, and the new target applies from then on.
- `new_game` and hit in the same cycle: the hit is discarded.
- `new_game` during DRAIN or mid-drain: the round restarts immediately; no partial drain completes.
- PLAY→DRAIN on the edge where the target reaches 0. DRAIN→OVER on the edge after the displayed values equal the targets.
- `game_over` and `winner` change on the same edge.
- Reset asserted mid-round: all outputs go to their reset values asynchronously.

## Structure
- Add to `variable_pkg`:
  - `HP_MAX_DEFAULT` (100)
  - `hp_state_t` enum (IDLE, PLAY, DRAIN, OVER)
  - winner codes `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`
- Sub-module `hp_drain`, instantiated once per player. Inputs: clk/rst, load (HP_MAX), tick, enable, and the target. It owns the displayed-value register and its saturating step.
- The top level owns the FSM, the target registers, and the tick detector.

## Test plan
- Reset, then `new_game` → both `hp_player`=100, `game_over`=0, `winner`=00. Hit in IDLE before `new_game` → no change.
- PLAY, `hit1_dmg`=30 → `tgt_hp1`=70. Across 30 vblnk rising edges `hp_player1` steps 99…70, one per frame; `hp_player2` stays 100.
- Hit2 `dmg`=120 with target 100 → target 0 (saturated), state DRAIN. After 100 ticks `hp_player2`=0; next edge `game_over`=1, `winner`=01.
- Simultaneous `hit1`/`hit2`, `dmg`=100 each → both targets 0. After drain, `winner`=11.
- `DRAIN_STEP`=8, target 70 from 100 → displayed 92, 84, 76, 70 (last step clipped to 6).
- `new_game` in the same cycle as `hit1` during DRAIN → state PLAY, both HP 100, hit discarded. Async `rst` pulse mid-drain → reset values with no clock edge.

Source files
------------

// File: rtl/variable_pkg.sv
// Shared game constants: HP limits, round state encoding and winner codes.
// Also carries the saturating HP subtract used when damage is applied.
package variable_pkg;

    localparam logic [6:0] HP_MAX_DEFAULT = 7'd100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        OVER  = 2'd3
    } hp_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Damage at or above the remaining HP clamps to zero instead of wrapping.
    function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
        if (dmg >= hp) begin
            return 7'd0;
        end else begin
            return hp - dmg;
        end
    endfunction

endpackage

// File: rtl/hp_drain.sv
// Displayed-HP register for one player: steps down toward the true HP by at
// most DRAIN_STEP per frame tick and never undershoots the target.
module hp_drain
    import variable_pkg::*;
#(
    parameter logic [6:0] HP_MAX     = HP_MAX_DEFAULT,
    parameter logic [6:0] DRAIN_STEP = 7'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       tick,
    input  logic       enable,
    input  logic [6:0] tgt,
    output logic [6:0] hp
);

    logic [6:0] gap_s;
    logic [6:0] step_s;

    // Clip the step to the remaining gap so the last frame lands exactly on target.
    always_comb begin
        gap_s = hp - tgt;
        if (gap_s < DRAIN_STEP) begin
            step_s = gap_s;
        end else begin
            step_s = DRAIN_STEP;
        end
    end

    // Displayed value register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp <= HP_MAX;
        end else if (load) begin
            hp <= HP_MAX;
        end else if (enable && tick && (hp > tgt)) begin
            hp <= hp - step_s;
        end
    end

endmodule

// File: rtl/hp_ctrl.sv
// Round controller: owns both players' true HP, the round FSM and the frame
// tick detector; one hp_drain per player produces the displayed HP.
module hp_ctrl
    import variable_pkg::*;
#(
    parameter logic [6:0] HP_MAX     = HP_MAX_DEFAULT,
    parameter logic [6:0] DRAIN_STEP = 7'd1
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       new_game,
    input  logic       vblnk,
    input  logic       hit1_valid,
    input  logic [6:0] hit1_dmg,
    input  logic       hit2_valid,
    input  logic [6:0] hit2_dmg,
    output logic [6:0] hp_player1,
    output logic [6:0] hp_player2,
    output logic       game_over,
    output logic [1:0] winner
);

    hp_state_t  state_r;
    hp_state_t  next_state_s;
    logic [6:0] tgt_hp1_r;
    logic [6:0] tgt_hp2_r;
    logic [6:0] tgt_hp1_s;
    logic [6:0] tgt_hp2_s;
    logic       vblnk_d_r;
    logic       tick_s;
    logic       drain_en_s;
    logic       settled_s;
    logic       game_over_s;
    logic [1:0] winner_s;

    assign tick_s     = vblnk & ~vblnk_d_r;
    assign drain_en_s = (state_r == PLAY) || (state_r == DRAIN);
    assign settled_s  = (hp_player1 == tgt_hp1_r) && (hp_player2 == tgt_hp2_r);

    // Target update: only PLAY accepts damage, and new_game discards any hit.
    always_comb begin
        tgt_hp1_s = tgt_hp1_r;
        tgt_hp2_s = tgt_hp2_r;
        if (new_game) begin
            tgt_hp1_s = HP_MAX;
            tgt_hp2_s = HP_MAX;
        end else if (state_r == PLAY) begin
            if (hit1_valid) begin
                tgt_hp1_s = sat_sub(tgt_hp1_r, hit1_dmg);
            end else begin
                tgt_hp1_s = tgt_hp1_r;
            end
            if (hit2_valid) begin
                tgt_hp2_s = sat_sub(tgt_hp2_r, hit2_dmg);
            end else begin
                tgt_hp2_s = tgt_hp2_r;
            end
        end else begin
            tgt_hp1_s = tgt_hp1_r;
            tgt_hp2_s = tgt_hp2_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        if (new_game) begin
            next_state_s = PLAY;
        end else begin
            case (state_r)
                IDLE:    next_state_s = IDLE;
                PLAY:    next_state_s = ((tgt_hp1_s == 7'd0) || (tgt_hp2_s == 7'd0)) ? DRAIN : PLAY;
                DRAIN:   next_state_s = settled_s ? OVER : DRAIN;
                OVER:    next_state_s = OVER;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output logic: winner is decided from the targets on the DRAIN->OVER edge.
    always_comb begin
        game_over_s = (next_state_s == OVER);
        winner_s    = winner;
        if (new_game) begin
            winner_s = WIN_NONE;
        end else if ((state_r == DRAIN) && (next_state_s == OVER)) begin
            if ((tgt_hp1_r == 7'd0) && (tgt_hp2_r == 7'd0)) begin
                winner_s = WIN_DRAW;
            end else if (tgt_hp1_r == 7'd0) begin
                winner_s = WIN_P2;
            end else if (tgt_hp2_r == 7'd0) begin
                winner_s = WIN_P1;
            end else begin
                winner_s = WIN_NONE;
            end
        end else begin
            winner_s = winner;
        end
    end

    // State, targets, tick history and registered round outputs.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            tgt_hp1_r <= HP_MAX;
            tgt_hp2_r <= HP_MAX;
            vblnk_d_r <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            state_r   <= next_state_s;
            tgt_hp1_r <= tgt_hp1_s;
            tgt_hp2_r <= tgt_hp2_s;
            vblnk_d_r <= vblnk;
            game_over <= game_over_s;
            winner    <= winner_s;
        end
    end

    hp_drain #(.HP_MAX(HP_MAX), .DRAIN_STEP(DRAIN_STEP)) u_drain1 (
        .clk    (clk60MHz),
        .rst    (rst),
        .load   (new_game),
        .tick   (tick_s),
        .enable (drain_en_s),
        .tgt    (tgt_hp1_r),
        .hp     (hp_player1)
    );

    hp_drain #(.HP_MAX(HP_MAX), .DRAIN_STEP(DRAIN_STEP)) u_drain2 (
        .clk    (clk60MHz),
        .rst    (rst),
        .load   (new_game),
        .tick   (tick_s),
        .enable (drain_en_s),
        .tgt    (tgt_hp2_r),
        .hp     (hp_player2)
    );

endmodule
